// File: rtl/mux_scan_nxw.sv
// N-channel, W-bit registered mux with a debounced manual select and a divided auto-scan.
// y and ch are always updated together, so ch names the channel that y was taken from.
module mux_scan_nxw #(
    parameter int unsigned W        = 2,
    parameter int unsigned N        = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEB      = 16,
    localparam int unsigned SW      = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    input  logic [1:0]     mode,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  ch,
    output logic           tick
);

    localparam int unsigned DVW = $clog2(SCAN_DIV);
    localparam int unsigned DCW = $clog2(DEB);

    typedef enum logic [1:0] {
        ModeManual = 2'b00,
        ModeUp     = 2'b01,
        ModeDown   = 2'b10,
        ModeFreeze = 2'b11
    } mode_e;

    logic [SW-1:0]  cand_q, cand_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [SW-1:0]  sel_db_q, sel_db_d;
    logic [1:0]     mode_q;
    logic [DVW-1:0] dv_q, dv_d;
    logic [SW-1:0]  ch_q, ch_d, ch_next;
    logic [W-1:0]   y_q, y_d;
    logic           tick_q, tick_d;
    logic           hold;

    // Debouncer: sel must match cand for DEB consecutive samples before sel_db follows.
    always_comb begin
        cand_d   = cand_q;
        dcnt_d   = dcnt_q;
        sel_db_d = sel_db_q;
        if (sel != cand_q) begin
            cand_d = sel;
            dcnt_d = '0;
        end else if (dcnt_q != DCW'(DEB - 1)) begin
            dcnt_d = dcnt_q + 1'b1;
        end
        if (dcnt_q == DCW'(DEB - 1) && cand_q != sel_db_q) begin
            sel_db_d = cand_q;
        end
    end

    always_comb begin
        ch_next = ch_q;
        dv_d    = dv_q;
        tick_d  = 1'b0;
        hold    = 1'b0;
        unique case (mode_e'(mode))
            ModeManual: begin
                if (32'(sel_db_q) < N) begin
                    ch_next = sel_db_q;
                end
            end
            ModeUp, ModeDown: begin
                // Transitions through freeze keep the divider so scanning resumes in place.
                if (mode != mode_q && mode_q != ModeFreeze) begin
                    dv_d = '0;
                end else if (dv_q == DVW'(SCAN_DIV - 1)) begin
                    dv_d   = '0;
                    tick_d = 1'b1;
                    if (mode == ModeUp) begin
                        ch_next = (ch_q == SW'(N - 1)) ? '0 : ch_q + 1'b1;
                    end else begin
                        ch_next = (ch_q == '0) ? SW'(N - 1) : ch_q - 1'b1;
                    end
                end else begin
                    dv_d = dv_q + 1'b1;
                end
            end
            ModeFreeze: begin
                hold = 1'b1;
            end
            default: begin
                hold = 1'b1;
            end
        endcase
    end

    always_comb begin
        y_d  = y_q;
        ch_d = ch_next;
        for (int i = 0; i < int'(N); i++) begin
            if (ch_next == SW'(i)) begin
                y_d = din[i*W +: W];
            end
        end
        if (hold) begin
            ch_d = ch_q;
            y_d  = y_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q   <= '0;
            dcnt_q   <= '0;
            sel_db_q <= '0;
            mode_q   <= 2'b00;
            dv_q     <= '0;
            ch_q     <= '0;
            y_q      <= '0;
            tick_q   <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            dcnt_q   <= dcnt_d;
            sel_db_q <= sel_db_d;
            mode_q   <= mode;
            dv_q     <= dv_d;
            ch_q     <= ch_d;
            y_q      <= y_d;
            tick_q   <= tick_d;
        end
    end

    assign y    = y_q;
    assign ch   = ch_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_mux_scan_nxw.sv
// Self-checking bench for mux_scan_nxw: manual/debounce table, scan/freeze/reset sequences,
// and an N=3 instance for the out-of-range select case.
module tb_mux_scan_nxw;

    localparam logic [7:0] DinA = 8'b11_10_01_00;  // channel i carries value i
    localparam logic [7:0] DinB = 8'b00_01_10_11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = DinA;
    logic [1:0] sel = 2'd0;
    logic [1:0] mode = 2'b00;
    logic [1:0] y;
    logic [1:0] ch;
    logic       tick;

    logic [5:0] din3 = 6'b10_01_00;
    logic [1:0] sel3 = 2'd0;
    logic [1:0] mode3 = 2'b00;
    logic [1:0] y3;
    logic [1:0] ch3;
    logic       tick3;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int ch;
        int y;
        int tick;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] sel;
        logic [7:0] din;
        int         ch;
        int         y;
        int         tick;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[19];

    mux_scan_nxw #(.W(2), .N(4), .SCAN_DIV(4), .DEB(4)) dut (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
        .y(y), .ch(ch), .tick(tick)
    );

    mux_scan_nxw #(.W(2), .N(3), .SCAN_DIV(4), .DEB(4)) dut3 (
        .clk(clk), .rst(rst), .din(din3), .sel(sel3), .mode(mode3),
        .y(y3), .ch(ch3), .tick(tick3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end of test, required $finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // One clock: drive inputs, queue expectation, compare after the edge.
    task automatic step(input string name, input logic [1:0] m, input logic [1:0] s,
                        input logic [7:0] d, input int ec, input int ey, input int et);
        exp_t e;
        mode = m;
        sel  = s;
        din  = d;
        sb.push_back('{ch: ec, y: ey, tick: et});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({name, ".ch"}, int'(ch), e.ch);
        check({name, ".y"}, int'(y), e.y);
        check({name, ".tick"}, int'(tick), e.tick);
    endtask

    initial begin
        int cur;

        vecs = '{
            '{2'b00, 2'd0, DinA, 0, 0, 0},
            '{2'b00, 2'd2, DinA, 0, 0, 0},
            '{2'b00, 2'd2, DinA, 0, 0, 0},
            '{2'b00, 2'd2, DinA, 0, 0, 0},
            '{2'b00, 2'd2, DinA, 0, 0, 0},
            '{2'b00, 2'd2, DinA, 0, 0, 0},
            '{2'b00, 2'd2, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 2, 2, 0},
            '{2'b00, 2'd2, DinA, 2, 2, 0},
            '{2'b00, 2'd2, DinA, 2, 2, 0},
            '{2'b00, 2'd2, DinB, 2, 1, 0},
            '{2'b00, 2'd2, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 2, 2, 0},
            '{2'b00, 2'd3, DinA, 3, 3, 0}
        };

        #12;
        check("reset.y", int'(y), 0);
        check("reset.ch", int'(ch), 0);
        check("reset.tick", int'(tick), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Manual mode: debounce latency, glitch rejection, din tracking.
        for (int i = 0; i < 19; i++) begin
            step($sformatf("man%0d", i), vecs[i].mode, vecs[i].sel, vecs[i].din,
                 vecs[i].ch, vecs[i].y, vecs[i].tick);
        end

        // Scan-up from ch=3: mode change clears divider, then a tick every 4th cycle.
        step("up_enter", 2'b01, 2'd3, DinA, 3, 3, 0);
        cur = 3;
        for (int s = 0; s < 5; s++) begin
            for (int j = 0; j < 3; j++) step($sformatf("up%0d_%0d", s, j), 2'b01, 2'd3, DinA,
                                             cur, cur, 0);
            cur = (cur + 1) % 4;
            step($sformatf("up%0d_tick", s), 2'b01, 2'd3, DinA, cur, cur, 1);
        end

        // Scan-down from ch=0 wraps to 3; switching to up mid-count restarts the divider.
        step("dn_enter", 2'b10, 2'd3, DinA, 0, 0, 0);
        for (int j = 0; j < 3; j++) step("dn_wait", 2'b10, 2'd3, DinA, 0, 0, 0);
        step("dn_tick", 2'b10, 2'd3, DinA, 3, 3, 1);
        for (int j = 0; j < 2; j++) step("dn_mid", 2'b10, 2'd3, DinA, 3, 3, 0);
        step("sw_up", 2'b01, 2'd3, DinA, 3, 3, 0);
        for (int j = 0; j < 3; j++) step("sw_wait", 2'b01, 2'd3, DinA, 3, 3, 0);
        step("sw_tick", 2'b01, 2'd3, DinA, 0, 0, 1);
        for (int j = 0; j < 2; j++) step("pre_frz", 2'b01, 2'd3, DinA, 0, 0, 0);

        // Freeze with divider at 2: din toggles must not reach y; resume needs two edges.
        step("frz0", 2'b11, 2'd3, DinA, 0, 0, 0);
        step("frz1", 2'b11, 2'd3, DinB, 0, 0, 0);
        step("frz2", 2'b11, 2'd3, DinA, 0, 0, 0);
        step("frz3", 2'b11, 2'd3, DinB, 0, 0, 0);
        step("res0", 2'b01, 2'd3, DinA, 0, 0, 0);
        step("res_tick", 2'b01, 2'd3, DinA, 1, 1, 1);
        for (int j = 0; j < 2; j++) step("pre_rst", 2'b01, 2'd3, DinA, 1, 1, 0);

        // Asynchronous reset between edges mid-scan.
        #2 rst = 1'b0;
        #1;
        check("arst.y", int'(y), 0);
        check("arst.ch", int'(ch), 0);
        check("arst.tick", int'(tick), 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.ch", int'(ch), 0);
        check("post_rst.tick", int'(tick), 0);
        for (int j = 0; j < 3; j++) step("rst_wait", 2'b01, 2'd3, DinA, 0, 0, 0);
        step("rst_tick", 2'b01, 2'd3, DinA, 1, 1, 1);

        // N=3: out-of-range select 3 is ignored, ch holds and y keeps tracking din[ch].
        sel3 = 2'd2;
        repeat (7) @(posedge clk);
        #1;
        check("n3.ch", int'(ch3), 2);
        check("n3.y", int'(y3), 2);
        sel3 = 2'd3;
        repeat (10) @(posedge clk);
        #1;
        check("n3_oor.ch", int'(ch3), 2);
        check("n3_oor.y", int'(y3), 2);
        check("n3_oor.tick", int'(tick3), 0);
        din3 = 6'b01_10_00;
        @(posedge clk);
        #1;
        check("n3_track.y", int'(y3), 1);
        check("n3_track.ch", int'(ch3), 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
